// File: rtl/serializer_pkg.sv
// Shared definitions for the serial link (serializer / deserializer pair).
package serializer_pkg;

   // Default word width used by both ends of the link.
   localparam int SER_DATA_WIDTH = 8;

   // Transmitter control states.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage : serializer_pkg

// File: rtl/serializer.sv
// Parallel-to-serial transmitter for the 100 kHz domain.
// Words enter a one-deep holding register through a ready/load handshake.
// They then move into a shift register that emits one bit per unstalled
// cycle on data_out, qualified by a registered write_out strobe. A word held
// before the last bit's edge follows the current word with no gap.
module serializer
   import serializer_pkg::*;
#(
   parameter int DATA_WIDTH = SER_DATA_WIDTH,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clock_100k,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  load_in,
   output logic                  ready_out,
   input  logic                  hold_in,
   output logic                  data_out,
   output logic                  write_out,
   output logic                  byte_done_out,
   output logic                  busy_out
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   ser_state_t            state_reg;
   ser_state_t            state_next;

   logic [DATA_WIDTH-1:0] hold_reg;
   logic                  hold_full_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  data_reg;
   logic                  write_reg;
   logic                  byte_done_reg;

   // Decoded per-cycle control
   logic                  accept;      // capture data_in into the holding register
   logic                  emit;        // send one bit this edge
   logic                  last_bit;    // the bit being sent is the word's final bit
   logic                  load_shift;  // holding register moves to the shift register
   logic                  next_bit;    // bit presented by the shift register

   // State register
   always_ff @(posedge clock_100k) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: start when a word is held, stop after the last bit unless another is queued
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (hold_full_reg) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit && !hold_full_reg) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode from the current state
   always_comb begin
      busy_out   = (state_reg != IDLE);
      ready_out  = !hold_full_reg;
      accept     = load_in && !hold_full_reg;
      emit       = (state_reg == SHIFT) && !hold_in;
      last_bit   = emit && (cnt_reg == LAST_CNT);
      load_shift = hold_full_reg && ((state_reg == IDLE) || last_bit);
      next_bit   = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
   end

   // Holding register: accept only when empty; a transfer empties it.
   // Accept and transfer are mutually exclusive because they need opposite hold_full values.
   always_ff @(posedge clock_100k) begin
      if (reset) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else if (accept) begin
         hold_reg      <= data_in;
         hold_full_reg <= 1'b1;
      end else if (load_shift) begin
         hold_full_reg <= 1'b0;
      end
   end

   // Shift register and bit counter; a reload takes priority over shifting on the last-bit edge
   always_ff @(posedge clock_100k) begin
      if (reset) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (load_shift) begin
         shift_reg <= hold_reg;
         cnt_reg   <= '0;
      end else if (emit) begin
         if (MSB_FIRST) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
         end else begin
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
         end
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Registered serial outputs; data_out keeps its last value whenever no bit is emitted
   always_ff @(posedge clock_100k) begin
      if (reset) begin
         data_reg      <= 1'b0;
         write_reg     <= 1'b0;
         byte_done_reg <= 1'b0;
      end else begin
         write_reg     <= emit;
         byte_done_reg <= last_bit;
         if (emit) begin
            data_reg <= next_bit;
         end
      end
   end

   assign data_out      = data_reg;
   assign write_out     = write_reg;
   assign byte_done_out = byte_done_reg;

endmodule : serializer

// File: tb/tb_serializer.sv
// Directed bench for the serializer. A queue-based word/bit model predicts every
// output each cycle; hand-written bit sequences pin the observed line contents.
module tb_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       load_in;
   logic       hold_in;
   logic       ready_out, data_out, write_out, byte_done_out, busy_out;
   logic       l_ready, l_data, l_write, l_done, l_busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clock_100k   (clk),
      .reset        (reset),
      .data_in      (data_in),
      .load_in      (load_in),
      .ready_out    (ready_out),
      .hold_in      (hold_in),
      .data_out     (data_out),
      .write_out    (write_out),
      .byte_done_out(byte_done_out),
      .busy_out     (busy_out)
   );

   serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clock_100k   (clk),
      .reset        (reset),
      .data_in      (data_in),
      .load_in      (load_in),
      .ready_out    (l_ready),
      .hold_in      (hold_in),
      .data_out     (l_data),
      .write_out    (l_write),
      .byte_done_out(l_done),
      .busy_out     (l_busy)
   );

   // ---------------- behavioural model (MSB-first instance) ----------------
   bit         m_valid = 1'b0;
   bit         m_hold_valid;
   logic [7:0] m_hold_word;
   logic       m_bits[$];
   bit         m_busy;
   logic       m_data, m_write, m_done;

   task automatic model_step();
      bit do_accept;
      bit do_transfer;
      if (reset) begin
         m_valid      = 1'b1;
         m_hold_valid = 1'b0;
         m_bits.delete();
         m_busy       = 1'b0;
         m_data       = 1'b0;
         m_write      = 1'b0;
         m_done       = 1'b0;
      end else if (m_valid) begin
         do_accept   = load_in && !m_hold_valid;
         do_transfer = 1'b0;
         m_write     = 1'b0;
         m_done      = 1'b0;
         if (m_busy && !hold_in) begin
            m_data  = m_bits.pop_front();
            m_write = 1'b1;
            if (m_bits.size() == 0) begin
               m_done = 1'b1;
               if (m_hold_valid) do_transfer = 1'b1;
               else              m_busy      = 1'b0;
            end
         end else if (!m_busy && m_hold_valid) begin
            do_transfer = 1'b1;
            m_busy      = 1'b1;
         end
         if (do_transfer) begin
            for (int i = 7; i >= 0; i--) m_bits.push_back(m_hold_word[i]);
            m_hold_valid = 1'b0;
         end
         if (do_accept) begin
            m_hold_word  = data_in;
            m_hold_valid = 1'b1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Observed line: bits strobed by each DUT, the cycle they appeared in, and byte_done positions.
   logic line_bits[$];
   int   line_cyc[$];
   int   done_idx[$];
   logic lsb_bits[$];
   int   cyc = 0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (write_out === 1'b1) begin
         line_bits.push_back(data_out);
         line_cyc.push_back(cyc);
      end
      if (byte_done_out === 1'b1) done_idx.push_back(line_bits.size() - 1);
      if (l_write === 1'b1) lsb_bits.push_back(l_data);
      if (m_valid) begin
         check("cyc_data_out",  {31'd0, data_out},      {31'd0, m_data});
         check("cyc_write_out", {31'd0, write_out},     {31'd0, m_write});
         check("cyc_byte_done", {31'd0, byte_done_out}, {31'd0, m_done});
         check("cyc_busy",      {31'd0, busy_out},      {31'd0, m_busy});
         check("cyc_ready",     {31'd0, ready_out},     {31'd0, !m_hold_valid});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_line();
      line_bits.delete();
      line_cyc.delete();
      done_idx.delete();
      lsb_bits.delete();
   endtask

   // Expected bits are written in transmit order, leftmost first.
   task automatic check_line(input string name, input logic q[$], input int n, input logic [15:0] exp);
      check($sformatf("%s_len", name), q.size(), n);
      for (int i = 0; i < n && i < q.size(); i++)
         check($sformatf("%s_bit%0d", name, i), {31'd0, q[i]}, {31'd0, exp[15-i]});
   endtask

   task automatic send(input logic [7:0] w);
      int n = 0;
      while (ready_out !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("send_ready_wait", {31'd0, ready_out}, 32'd1);
      data_in = w;
      load_in = 1'b1;
      tick();
      load_in = 1'b0;
   endtask

   task automatic wait_bits(input int n);
      int k = 0;
      while (line_bits.size() < n && k < 40) begin
         tick();
         k++;
      end
      check("wait_bits_count", line_bits.size(), n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset   = 1'b1;
      load_in = 1'b0;
      hold_in = 1'b0;
      data_in = 8'h00;
      tick(2);
      check("rst_data_out",  {31'd0, data_out},      32'd0);
      check("rst_write_out", {31'd0, write_out},     32'd0);
      check("rst_byte_done", {31'd0, byte_done_out}, 32'd0);
      check("rst_busy",      {31'd0, busy_out},      32'd0);
      check("rst_ready",     {31'd0, ready_out},     32'd1);
      reset = 1'b0;
      tick();

      // Single word 0xA5: latency E0 accept, E1 transfer, E2 first bit.
      clear_line();
      send(8'hA5);
      check("a5_e0_busy",  {31'd0, busy_out},  32'd0);
      check("a5_e0_write", {31'd0, write_out}, 32'd0);
      check("a5_e0_ready", {31'd0, ready_out}, 32'd0);
      tick();
      check("a5_e1_busy",  {31'd0, busy_out},  32'd1);
      check("a5_e1_write", {31'd0, write_out}, 32'd0);
      check("a5_e1_ready", {31'd0, ready_out}, 32'd1);
      tick();
      check("a5_e2_write", {31'd0, write_out}, 32'd1);
      check("a5_e2_data",  {31'd0, data_out},  32'd1);
      tick(12);
      check_line("a5", line_bits, 8, 16'b10100101_00000000);
      check("a5_done_count", done_idx.size(), 1);
      if (done_idx.size() > 0) check("a5_done_pos", done_idx[0], 7);
      if (line_cyc.size() == 8) check("a5_contig", line_cyc[7] - line_cyc[0], 7);
      check("a5_idle_busy", {31'd0, busy_out}, 32'd0);

      // Back-to-back 0x3C then 0xFF; a third load of 0x11 must be dropped.
      clear_line();
      send(8'h3C);
      send(8'hFF);
      check("b2b_held_ready", {31'd0, ready_out}, 32'd0);
      tick(2);
      check("drop_ready_low", {31'd0, ready_out}, 32'd0);
      data_in = 8'h11;
      load_in = 1'b1;
      tick();
      load_in = 1'b0;
      tick(25);
      check_line("b2b", line_bits, 16, 16'b00111100_11111111);
      if (line_cyc.size() == 16) check("b2b_contig", line_cyc[15] - line_cyc[0], 15);
      check("b2b_done_count", done_idx.size(), 2);
      if (done_idx.size() == 2) begin
         check("b2b_done_first", done_idx[0], 7);
         check("b2b_done_gap",   done_idx[1] - done_idx[0], 8);
      end

      // Stall for 3 cycles after the 4th bit of 0x96.
      clear_line();
      send(8'h96);
      wait_bits(4);
      hold_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall%0d_write", i), {31'd0, write_out}, 32'd0);
         check($sformatf("stall%0d_data",  i), {31'd0, data_out},  32'd1);
      end
      hold_in = 1'b0;
      tick(12);
      check_line("stall", line_bits, 8, 16'b10010110_00000000);
      if (line_cyc.size() == 8) begin
         check("stall_gap",  line_cyc[4] - line_cyc[3], 4);
         check("stall_span", line_cyc[7] - line_cyc[0], 10);
      end

      // Reset after 4 bits of 0xF0, then 0x81 transmits cleanly.
      clear_line();
      send(8'hF0);
      wait_bits(4);
      reset = 1'b1;
      tick();
      check("mid_rst_data_out",  {31'd0, data_out},      32'd0);
      check("mid_rst_write_out", {31'd0, write_out},     32'd0);
      check("mid_rst_byte_done", {31'd0, byte_done_out}, 32'd0);
      check("mid_rst_busy",      {31'd0, busy_out},      32'd0);
      check("mid_rst_ready",     {31'd0, ready_out},     32'd1);
      reset = 1'b0;
      tick(20);
      check_line("rst_f0", line_bits, 4, 16'b1111_000000000000);
      check("rst_after_ready", {31'd0, ready_out}, 32'd1);
      clear_line();
      send(8'h81);
      tick(12);
      check_line("post_rst_81", line_bits, 8, 16'b10000001_00000000);

      // LSB-first instance with 0x01 (main instance sends it MSB-first).
      clear_line();
      send(8'h01);
      tick(12);
      check_line("lsb_01", lsb_bits, 8, 16'b10000000_00000000);
      check_line("msb_01", line_bits, 8, 16'b00000001_00000000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 ns");
      $fatal(1, "timeout");
   end

endmodule : tb_serializer
